// File: rtl/cordic_hyperbolic_seq.sv
// Sequential hyperbolic CORDIC: rotation, vectoring, sinh/cosh and exp modes,
// one micro-iteration per clock with the 3k+1 repeats at shift indices 4 and 13.
module cordic_hyperbolic_seq #(
  parameter int WIDTH      = 32,
  parameter int FRAC       = 16,
  parameter int ITERATIONS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  input  logic [WIDTH-1:0] z_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] x_out,
  output logic [WIDTH-1:0] y_out,
  output logic [WIDTH-1:0] z_out,
  output logic             out_of_range
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_e;
  typedef enum logic [1:0] {M_ROT = 2'b00, M_VEC = 2'b01, M_SINHCOSH = 2'b10, M_EXP = 2'b11} mode_e;

  localparam int STEPS = ITERATIONS + ((ITERATIONS >= 4) ? 1 : 0) + ((ITERATIONS >= 13) ? 1 : 0);
  localparam logic [5:0] LAST_STEP = 6'(STEPS - 1);

  // round(num/den * 2^FRAC), evaluated at elaboration
  function automatic longint scale_q(longint num, longint den);
    longint p;
    longint r;
    p = num <<< ((FRAC > 30) ? 30 : FRAC);
    r = (p + den / 2) / den;
    if (FRAC > 30) r = r <<< (FRAC - 30);
    return r;
  endfunction

  localparam logic signed [WIDTH-1:0] INV_GAIN = WIDTH'(scale_q(64'sd6037485339, 64'sd5000000000));
  localparam logic signed [WIDTH:0]   Z_LIMIT  = (WIDTH+1)'(scale_q(64'sd11181, 64'sd10000));

  function automatic longint atanh_q30(logic [4:0] idx);
    case (idx)
      5'd1:    return 64'sd589812981;
      5'd2:    return 64'sd274247419;
      5'd3:    return 64'sd134923406;
      5'd4:    return 64'sd67196451;
      5'd5:    return 64'sd33565361;
      5'd6:    return 64'sd16778582;
      5'd7:    return 64'sd8388779;
      5'd8:    return 64'sd4194325;
      5'd9:    return 64'sd2097155;
      5'd10:   return 64'sd1048576;
      default: return (idx >= 5'd11 && idx <= 5'd30) ? (64'sd1 <<< (5'd30 - idx)) : 64'sd0;
    endcase
  endfunction

  function automatic logic signed [WIDTH-1:0] atanh_frac(logic [4:0] idx);
    longint t;
    t = atanh_q30(idx);
    if (FRAC < 30) t = (t + (64'sd1 <<< (29 - FRAC))) >>> (30 - FRAC);
    else           t = t <<< (FRAC - 30);
    return WIDTH'(t);
  endfunction

  function automatic logic signed [WIDTH:0] mag(logic [WIDTH-1:0] v);
    logic signed [WIDTH:0] e;
    e = {v[WIDTH-1], v};
    return e[WIDTH] ? -e : e;
  endfunction

  state_e                  state_q, state_d;
  mode_e                   mode_q, mode_d;
  logic signed [WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic [4:0]              idx_q, idx_d;
  logic                    rep_q, rep_d;
  logic [5:0]              step_q, step_d;
  logic                    oor_pend_q, oor_pend_d;
  logic [WIDTH-1:0]        x_out_q, x_out_d, y_out_q, y_out_d, z_out_q, z_out_d;
  logic                    oor_q, oor_d, done_q, done_d;

  logic signed [WIDTH-1:0] x_sh, y_sh, atanh_i, x_step, y_step, z_step;
  logic                    dir_pos, load_oor;

  always_comb begin
    x_sh    = x_q >>> idx_q;
    y_sh    = y_q >>> idx_q;
    atanh_i = atanh_frac(idx_q);
    // Vectoring drives y toward zero; rotation drives z toward zero.
    dir_pos = (mode_q == M_VEC) ? y_q[WIDTH-1] : ~z_q[WIDTH-1];
    if (dir_pos) begin
      x_step = x_q + y_sh;
      y_step = y_q + x_sh;
      z_step = z_q - atanh_i;
    end else begin
      x_step = x_q - y_sh;
      y_step = y_q - x_sh;
      z_step = z_q + atanh_i;
    end
    load_oor = (mode == 2'b01) ? (x_in[WIDTH-1] || (x_in == '0) || (mag(y_in) >= mag(x_in)))
                               : (mag(z_in) > Z_LIMIT);
  end

  // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    x_d        = x_q;
    y_d        = y_q;
    z_d        = z_q;
    idx_d      = idx_q;
    rep_d      = rep_q;
    step_d     = step_q;
    oor_pend_d = oor_pend_q;
    x_out_d    = x_out_q;
    y_out_d    = y_out_q;
    z_out_d    = z_out_q;
    oor_d      = oor_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_RUN;
          mode_d     = mode_e'(mode);
          idx_d      = 5'd1;
          rep_d      = 1'b0;
          step_d     = '0;
          oor_pend_d = load_oor;
          case (mode_e'(mode))
            M_ROT:   begin x_d = x_in;     y_d = y_in; z_d = z_in; end
            M_VEC:   begin x_d = x_in;     y_d = y_in; z_d = '0;   end
            default: begin x_d = INV_GAIN; y_d = '0;   z_d = z_in; end
          endcase
        end
      end
      S_RUN: begin
        x_d    = x_step;
        y_d    = y_step;
        z_d    = z_step;
        step_d = step_q + 6'd1;
        if ((idx_q == 5'd4 || idx_q == 5'd13) && !rep_q) begin
          rep_d = 1'b1;
        end else begin
          idx_d = idx_q + 5'd1;
          rep_d = 1'b0;
        end
        if (step_q == LAST_STEP) state_d = S_FIN;
      end
      S_FIN: begin
        x_out_d = (mode_q == M_EXP) ? x_q + y_q : x_q;
        y_out_d = y_q;
        z_out_d = z_q;
        oor_d   = oor_pend_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mode_q     <= M_ROT;
      x_q        <= '0;
      y_q        <= '0;
      z_q        <= '0;
      idx_q      <= '0;
      rep_q      <= 1'b0;
      step_q     <= '0;
      oor_pend_q <= 1'b0;
      x_out_q    <= '0;
      y_out_q    <= '0;
      z_out_q    <= '0;
      oor_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      x_q        <= x_d;
      y_q        <= y_d;
      z_q        <= z_d;
      idx_q      <= idx_d;
      rep_q      <= rep_d;
      step_q     <= step_d;
      oor_pend_q <= oor_pend_d;
      x_out_q    <= x_out_d;
      y_out_q    <= y_out_d;
      z_out_q    <= z_out_d;
      oor_q      <= oor_d;
      done_q     <= done_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign x_out        = x_out_q;
  assign y_out        = y_out_q;
  assign z_out        = z_out_q;
  assign out_of_range = oor_q;

endmodule

// File: tb/tb_cordic_hyperbolic_seq.sv
// Scoreboard bench for cordic_hyperbolic_seq: Q16.16 instance for all modes,
// plus a Q8.24 instance for a high-precision sinh/cosh sweep.
`timescale 1ns/1ps
module tb_cordic_hyperbolic_seq;

  localparam int  W     = 32;
  localparam real ONE16 = 65536.0;
  localparam real ONE24 = 16777216.0;
  localparam real K_H   = 1.0 / 1.2074970678;

  typedef struct {
    string  tag;
    bit     cx, cy, cz;
    longint ex, ey, ez, tol;
    logic   eoor;
    int     start_cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1, rst2 = 1'b1;
  logic         start = 1'b0, start2 = 1'b0;
  logic [1:0]   mode = 2'b00, mode2 = 2'b10;
  logic [W-1:0] x_in = '0, y_in = '0, z_in = '0;
  logic [W-1:0] x2_in = '0, y2_in = '0, z2_in = '0;
  logic         busy, done, oor, busy2, done2, oor2;
  logic [W-1:0] x_out, y_out, z_out, x2_out, y2_out, z2_out;

  int   checks = 0, errors = 0, cyc = 0;
  bit   fin2 = 1'b0;
  exp_t sb[$], sb2[$];

  cordic_hyperbolic_seq #(.WIDTH(32), .FRAC(16), .ITERATIONS(16)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .busy(busy), .done(done), .x_out(x_out), .y_out(y_out), .z_out(z_out),
    .out_of_range(oor));

  cordic_hyperbolic_seq #(.WIDTH(32), .FRAC(24), .ITERATIONS(24)) dut24 (
    .clk(clk), .rst(rst2), .start(start2), .mode(mode2),
    .x_in(x2_in), .y_in(y2_in), .z_in(z2_in),
    .busy(busy2), .done(done2), .x_out(x2_out), .y_out(y2_out), .z_out(z2_out),
    .out_of_range(oor2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint got, input longint exp, input longint tol);
    checks++;
    if (got > exp + tol || got < exp - tol) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  function automatic longint q(real v, real s);
    return longint'($rtoi(v * s + ((v < 0.0) ? -0.5 : 0.5)));
  endfunction

  function automatic real sh(real z);
    return ($exp(z) - $exp(-z)) / 2.0;
  endfunction

  function automatic real ch(real z);
    return ($exp(z) + $exp(-z)) / 2.0;
  endfunction

  function automatic real ath(real r);
    return 0.5 * $ln((1.0 + r) / (1.0 - r));
  endfunction

  function automatic exp_t mk(string tag, bit cx, bit cy, bit cz,
                              longint ex, longint ey, longint ez, longint tol, logic eoor);
    exp_t e;
    e.tag = tag; e.cx = cx; e.cy = cy; e.cz = cz;
    e.ex = ex; e.ey = ey; e.ez = ez; e.tol = tol; e.eoor = eoor; e.start_cyc = 0;
    return e;
  endfunction

  // Scoreboard monitors: outputs sampled on the falling edge.
  always @(negedge clk) begin : mon
    exp_t e;
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0, 0);
      end else begin
        e = sb.pop_front();
        check({e.tag, "_latency"}, cyc - e.start_cyc, 19, 0);
        check({e.tag, "_busy"}, busy, 0, 0);
        check({e.tag, "_oor"}, oor, e.eoor, 0);
        if (e.cx) check({e.tag, "_x"}, longint'($signed(x_out)), e.ex, e.tol);
        if (e.cy) check({e.tag, "_y"}, longint'($signed(y_out)), e.ey, e.tol);
        if (e.cz) check({e.tag, "_z"}, longint'($signed(z_out)), e.ez, e.tol);
      end
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (done2) begin
      if (sb2.size() == 0) begin
        check("q24_unexpected_done", 1, 0, 0);
      end else begin
        e = sb2.pop_front();
        check({e.tag, "_latency"}, cyc - e.start_cyc, 27, 0);
        check({e.tag, "_x"}, longint'($signed(x2_out)), e.ex, e.tol);
        check({e.tag, "_y"}, longint'($signed(y2_out)), e.ey, e.tol);
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("done_timeout", sb.size(), 0, 0);
      sb.delete();
    end
  endtask

  task automatic run_job(input logic [1:0] m, input longint xi, input longint yi,
                         input longint zi, input exp_t e);
    @(negedge clk);
    mode = m; x_in = W'(xi); y_in = W'(yi); z_in = W'(zi); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    e.start_cyc = cyc;
    sb.push_back(e);
    wait_idle();
  endtask

  initial begin : main
    real    zr, xv, yv;
    longint lim;
    exp_t   e;
    int     c0, n;

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0, 0);
    check("rst_done", done, 0, 0);
    check("rst_x", x_out, 0, 0);
    check("rst_y", y_out, 0, 0);
    check("rst_z", z_out, 0, 0);
    check("rst_oor", oor, 0, 0);
    rst = 1'b0;

    run_job(2'b10, 0, 0, q(1.0, ONE16), mk("sc_p1", 1, 1, 0, q(ch(1.0), ONE16), q(sh(1.0), ONE16), 0, 66, 1'b0));
    run_job(2'b10, 0, 0, q(-0.5, ONE16), mk("sc_m05", 1, 1, 0, q(ch(-0.5), ONE16), q(sh(-0.5), ONE16), 0, 66, 1'b0));
    run_job(2'b10, 0, 0, 0, mk("sc_zero", 1, 1, 0, 65536, 0, 0, 66, 1'b0));
    run_job(2'b11, 0, 0, q(0.5, ONE16), mk("exp_p05", 1, 0, 0, q($exp(0.5), ONE16), 0, 0, 66, 1'b0));
    run_job(2'b11, 0, 0, q(1.5, ONE16), mk("exp_oor", 0, 0, 0, 0, 0, 0, 0, 1'b1));
    run_job(2'b01, q(1.0, ONE16), q(0.5, ONE16), 0,
            mk("vec_a", 1, 1, 1, q(K_H * $sqrt(0.75), ONE16), 0, q(ath(0.5), ONE16), 66, 1'b0));
    run_job(2'b01, q(1.0, ONE16), q(-0.25, ONE16), 0,
            mk("vec_b", 1, 1, 1, q(K_H * $sqrt(0.9375), ONE16), 0, q(ath(-0.25), ONE16), 66, 1'b0));
    run_job(2'b01, q(0.5, ONE16), q(0.5, ONE16), 0, mk("vec_eq", 0, 0, 0, 0, 0, 0, 0, 1'b1));
    run_job(2'b01, q(0.5, ONE16), q(-0.5, ONE16), 0, mk("vec_eqn", 0, 0, 0, 0, 0, 0, 0, 1'b1));
    run_job(2'b01, q(-0.5, ONE16), q(0.1, ONE16), 0, mk("vec_negx", 0, 0, 0, 0, 0, 0, 0, 1'b1));

    zr = -0.3; xv = 0.5; yv = 0.25;
    run_job(2'b00, q(xv, ONE16), q(yv, ONE16), q(zr, ONE16),
            mk("rot", 1, 1, 1, q(K_H * (xv * ch(zr) + yv * sh(zr)), ONE16),
               q(K_H * (xv * sh(zr) + yv * ch(zr)), ONE16), 0, 66, 1'b0));

    lim = q(1.1181, ONE16);
    run_job(2'b00, 0, 0, lim,      mk("lim_at",    0, 0, 0, 0, 0, 0, 0, 1'b0));
    run_job(2'b00, 0, 0, lim + 1,  mk("lim_over",  0, 0, 0, 0, 0, 0, 0, 1'b1));
    run_job(2'b10, 0, 0, -lim,     mk("lim_neg",   0, 0, 0, 0, 0, 0, 0, 1'b0));
    run_job(2'b11, 0, 0, -lim - 1, mk("lim_nover", 0, 0, 0, 0, 0, 0, 0, 1'b1));

    // A second start during a running job must be ignored.
    @(negedge clk);
    mode = 2'b10; z_in = W'(q(0.75, ONE16)); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    e = mk("ignore", 1, 1, 0, q(ch(0.75), ONE16), q(sh(0.75), ONE16), 0, 66, 1'b0);
    e.start_cyc = cyc;
    sb.push_back(e);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("ignore_busy", busy, 1, 0);
    z_in = W'(q(-0.75, ONE16)); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();
    repeat (25) @(negedge clk);

    // Start held high: one job every STEPS+2 cycles.
    @(negedge clk);
    mode = 2'b10; z_in = W'(q(0.25, ONE16)); start = 1'b1;
    @(posedge clk); #1;
    c0 = cyc;
    e = mk("b2b_1", 1, 1, 0, q(ch(0.25), ONE16), q(sh(0.25), ONE16), 0, 66, 1'b0);
    e.start_cyc = c0;
    sb.push_back(e);
    e.tag = "b2b_2";
    e.start_cyc = c0 + 20;
    sb.push_back(e);
    repeat (20) @(posedge clk);
    #1 start = 1'b0;
    wait_idle();

    // Reset mid-job aborts with no done pulse and clears the outputs.
    @(negedge clk);
    mode = 2'b10; z_in = W'(q(0.5, ONE16)); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", busy, 0, 0);
    check("abort_done", done, 0, 0);
    check("abort_x", x_out, 0, 0);
    check("abort_y", y_out, 0, 0);
    check("abort_z", z_out, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("abort_idle", busy, 0, 0);

    for (int k = -110; k <= 110; k++) begin
      zr = k / 100.0;
      run_job(2'b10, 0, 0, q(zr, ONE16),
              mk($sformatf("sweep_%0d", k), 1, 1, 0, q(ch(zr), ONE16), q(sh(zr), ONE16), 0, 65, 1'b0));
    end

    n = 0;
    while (!fin2 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("q24_finished", fin2, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : drv2
    real  zr2;
    exp_t e2;
    int   n2;
    repeat (3) @(negedge clk);
    rst2 = 1'b0;
    for (int k = -22; k <= 22; k++) begin
      zr2 = k * 0.05;
      @(negedge clk);
      z2_in = W'(q(zr2, ONE24)); start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      e2 = mk($sformatf("q24_%0d", k), 1, 1, 0, q(ch(zr2), ONE24), q(sh(zr2), ONE24), 0, 167, 1'b0);
      e2.start_cyc = cyc;
      sb2.push_back(e2);
      n2 = 0;
      while (sb2.size() != 0 && n2 < 100) begin
        @(negedge clk);
        n2++;
      end
      if (sb2.size() != 0) begin
        check("q24_timeout", sb2.size(), 0, 0);
        sb2.delete();
      end
    end
    fin2 = 1'b1;
  end

endmodule
